// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
// Shared types and constants for the banked main-memory controller.
//   BUS_BYTES   : byte lanes on the default 64-bit bus
//   LANE_BITS   : bits needed to select a lane / bank
//   fsm_state_e : controller states IDLE -> WAIT -> RESP
//   lane_t      : one byte lane
// ----------------------------------------------------------------------------
package ram_pkg;

  localparam int BUS_SIZE_DEF = 64;
  localparam int BUS_BYTES    = BUS_SIZE_DEF / 8;
  localparam int LANE_BITS    = $clog2(BUS_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } fsm_state_e;

  typedef logic [7:0] lane_t;

endpackage

// File: rtl/ram_bank.sv
// ----------------------------------------------------------------------------
// ram_bank
// One byte-wide synchronous single-port RAM, depth 2^ROW_W, no reset.
// Read data is registered and only updates on an enabled cycle, so it holds
// the last access result while the controller waits on the response.
// Ports:
//   clk   : clock
//   en    : access enable (read always, write when we=1)
//   we    : write enable
//   addr  : row address
//   wdata : byte to write
//   rdata : registered read byte
// ----------------------------------------------------------------------------
module ram_bank
  import ram_pkg::*;
#(
  parameter int    ROW_W     = 21,
  parameter int    NB        = BUS_BYTES,
  parameter int    BANK_IDX  = 0,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [ROW_W-1:0] addr,
  input  lane_t            wdata,
  output lane_t            rdata
);

  localparam int DEPTH = 1 << ROW_W;

  lane_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_banked_ctrl.sv
// ----------------------------------------------------------------------------
// ram_banked_ctrl
// Byte-addressed, big-endian main memory built from BUS_SIZE/8 byte-wide
// banks so any access, aligned or not, completes in a single row cycle.
// One request outstanding at a time; response after READ_LATENCY cycles.
// Ports:
//   clk, rst_n (sync, active-low)
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_strb : request port
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                  : response port
// Lane k of a word is bits [BUS_SIZE-1-8k -: 8] and maps to byte addr+k.
// Optional feature macro: RAM_BOUNDS_CHECK_EN -- reject accesses that run
// past 2^RAM_WIDTH or carry non-zero upper address bits (rsp_err=1, no
// write, zero data). Without it, addresses wrap modulo 2^RAM_WIDTH.
// BUS_SIZE must be at least 16 (two or more banks).
// ----------------------------------------------------------------------------
module ram_banked_ctrl
  import ram_pkg::*;
#(
  parameter int    RAM_WIDTH    = 24,
  parameter int    ADDR_SIZE    = 56,
  parameter int    BUS_SIZE     = BUS_BYTES * 8,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "memory.txt"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_SIZE-1:0]  req_addr,
  input  logic [BUS_SIZE-1:0]   req_wdata,
  input  logic [BUS_SIZE/8-1:0] req_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BUS_SIZE-1:0]   rsp_rdata,
  output logic                  rsp_err
);

  localparam int NB    = BUS_SIZE / 8;
  localparam int OFS_W = $clog2(NB);
  localparam int ROW_W = RAM_WIDTH - OFS_W;

  fsm_state_e state, state_nxt;

  logic                 acc;
  logic [RAM_WIDTH-1:0] base;
  logic [OFS_W-1:0]     ofs;
  logic [ROW_W-1:0]     row, row_inc;
  logic                 req_err;

  assign req_ready = (state == IDLE);
  assign acc       = req_valid && req_ready;
  assign base      = req_addr[RAM_WIDTH-1:0];
  assign ofs       = base[OFS_W-1:0];
  assign row       = base[RAM_WIDTH-1:OFS_W];
  assign row_inc   = row + 1'b1;

`ifdef RAM_BOUNDS_CHECK_EN
  localparam logic [RAM_WIDTH:0] LAST_OFS = NB - 1;
  logic [RAM_WIDTH:0] last_addr;
  // Carry out of the last lane address means the access runs past the top.
  assign last_addr = {1'b0, base} + LAST_OFS;
  assign req_err   = last_addr[RAM_WIDTH] || (req_addr[ADDR_SIZE-1:RAM_WIDTH] != '0);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[ADDR_SIZE-1:RAM_WIDTH];
  assign req_err        = 1'b0;
`endif

  lane_t            wr_lanes   [NB];
  lane_t            bank_rdata [NB];
  logic [ROW_W-1:0] bank_row   [NB];
  logic             bank_we    [NB];

  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign wr_lanes[k] = req_wdata[BUS_SIZE-1-8*k -: 8];
  end

  // Bank b serves lane (b - ofs) mod NB; banks below the offset hold the
  // tail of a misaligned access and therefore sit one row higher.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [OFS_W-1:0] lane;
    assign lane        = OFS_W'(b) - ofs;
    assign bank_row[b] = (OFS_W'(b) >= ofs) ? row : row_inc;
    assign bank_we[b]  = acc && req_we && req_strb[lane] && !req_err;

    ram_bank #(
      .ROW_W    (ROW_W),
      .NB       (NB),
      .BANK_IDX (b),
      .INIT_FILE(INIT_FILE)
    ) u_bank (
      .clk  (clk),
      .en   (acc),
      .we   (bank_we[b]),
      .addr (bank_row[b]),
      .wdata(wr_lanes[lane]),
      .rdata(bank_rdata[b])
    );
  end

  // ---- stage p0: bank outputs registered on the accept edge ----
  logic [OFS_W-1:0]    ofs_p0;
  logic                we_p0, err_p0, vld_p0;
  logic [BUS_SIZE-1:0] rd_word, dat_p0;

  always_ff @(posedge clk) begin
    if (acc) begin
      ofs_p0 <= ofs;
      we_p0  <= req_we;
      err_p0 <= req_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= acc;
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NB; k++) begin
      rd_word[BUS_SIZE-1-8*k -: 8] = bank_rdata[OFS_W'(k) + ofs_p0];
    end
  end

  assign dat_p0 = (we_p0 || err_p0) ? '0 : rd_word;

  // ---- stages p1..p(READ_LATENCY-1): latency shift register ----
  logic [BUS_SIZE-1:0] tail_dat;
  logic                tail_err, tail_vld;

  if (READ_LATENCY == 1) begin : g_pipe0
    assign tail_dat = dat_p0;
    assign tail_err = err_p0;
    assign tail_vld = vld_p0;
  end else begin : g_pipe
    localparam int D = READ_LATENCY - 1;
    logic [BUS_SIZE-1:0] dat_pn [D];
    logic                err_pn [D];
    logic                vld_pn [D];

    always_ff @(posedge clk) begin
      dat_pn[0] <= dat_p0;
      err_pn[0] <= err_p0;
      for (int i = 1; i < D; i++) begin
        dat_pn[i] <= dat_pn[i-1];
        err_pn[i] <= err_pn[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < D; i++) vld_pn[i] <= 1'b0;
      end else begin
        vld_pn[0] <= vld_p0;
        for (int i = 1; i < D; i++) vld_pn[i] <= vld_pn[i-1];
      end
    end

    assign tail_dat = dat_pn[D-1];
    assign tail_err = err_pn[D-1];
    assign tail_vld = vld_pn[D-1];
  end

  // ---- control FSM: WAIT ends when the accepted access leaves the pipe ----
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc)       state_nxt = WAIT;
      WAIT:    if (tail_vld)  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // ---- response register: holds under back-pressure ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (tail_vld) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= tail_dat;
      rsp_err   <= tail_err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_banked_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_banked_ctrl
// Scoreboard bench for ram_banked_ctrl: a flat byte-array reference model
// computes each expected response when the request is accepted; a monitor
// compares responses (data, error flag, latency) as they are handed over.
// ----------------------------------------------------------------------------
module tb_ram_banked_ctrl;

  localparam int RW = 12;
  localparam int AW = 56;
  localparam int BW = 64;
  localparam int NB = BW / 8;
  localparam int RL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [BW-1:0] req_wdata = '0;
  logic [NB-1:0] req_strb = '0;
  logic          rsp_ready = 1'b1;
  logic          req_ready, rsp_valid, rsp_err;
  logic [BW-1:0] rsp_rdata;

  always #5 clk = ~clk;

  ram_banked_ctrl #(
    .RAM_WIDTH   (RW),
    .ADDR_SIZE   (AW),
    .BUS_SIZE    (BW),
    .READ_LATENCY(RL),
    .INIT_FILE   ("")
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_strb (req_strb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int id_ctr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] rdata;
    logic          err;
    int            acc_cyc;
    int            id;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] mdl [1<<RW];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: sampled on the falling edge, handshake completes on
  // the following rising edge.
  bit seen = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        if (!seen) check("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
        seen = 1'b1;
        if (rsp_ready) seen = 1'b0;
      end else begin
        if (!seen) begin
          check($sformatf("latency_%0d", sb[0].id), 64'(cyc - sb[0].acc_cyc), 64'(RL));
          seen = 1'b1;
        end
        if (rsp_ready) begin
          check($sformatf("rdata_%0d", sb[0].id), rsp_rdata, sb[0].rdata);
          check($sformatf("err_%0d", sb[0].id), {63'd0, rsp_err}, {63'd0, sb[0].err});
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Drive one request, wait (bounded) for acceptance, update the model.
  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] wd,
                      input logic [NB-1:0] strb, input bit track);
    exp_t          e;
    int            t;
    logic          err;
    logic [RW-1:0] a;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_strb  = strb;
    t = 0;
    while (!req_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) begin
      check("accept_timeout", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    err = 1'b0;
`ifdef RAM_BOUNDS_CHECK_EN
    if (addr[AW-1:RW] != '0) err = 1'b1;
    if (int'(addr[RW-1:0]) + NB - 1 >= (1 << RW)) err = 1'b1;
`endif
    e.rdata   = '0;
    e.err     = err;
    e.acc_cyc = cyc;
    e.id      = id_ctr;
    id_ctr++;
    for (int k = 0; k < NB; k++) begin
      a = addr[RW-1:0] + RW'(k);
      if (!err) begin
        if (we && strb[k]) mdl[a] = wd[BW-1-8*k -: 8];
        if (!we) e.rdata[BW-1-8*k -: 8] = mdl[a];
      end
    end
    if (track) sb.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    for (int i = 0; i < (1 << RW); i++) mdl[i] = 8'h00;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err",   {63'd0, rsp_err}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clear the whole array so model and RAM agree
    for (int r = 0; r < (1 << RW) / NB; r++) send(1'b1, AW'(r * NB), '0, 8'hFF, 1'b1);
    drain();

    // Aligned write / read
    send(1'b1, 'h10, 64'h0011223344556677, 8'hFF, 1'b1);
    send(1'b0, 'h10, '0, 8'h00, 1'b1);
    // Strobes: only lanes 0 and 7
    send(1'b1, 'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81, 1'b1);
    send(1'b0, 'h10, '0, 8'h00, 1'b1);
    // Misaligned write, then row views and the misaligned read
    send(1'b1, 'h23, 64'h0102030405060708, 8'hFF, 1'b1);
    send(1'b0, 'h20, '0, 8'h00, 1'b1);
    send(1'b0, 'h28, '0, 8'h00, 1'b1);
    send(1'b0, 'h23, '0, 8'h00, 1'b1);
    drain();

    // Back-pressure: response must hold for 10 cycles
    rsp_ready = 1'b0;
    send(1'b0, 'h23, '0, 8'h00, 1'b1);
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("bp_rsp_arrives", {63'd0, rsp_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", {63'd0, rsp_valid}, 64'd1);
      check("bp_rdata_hold", rsp_rdata, 64'h0102030405060708);
      check("bp_req_ready",  {63'd0, req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {63'd0, rsp_valid}, 64'd0);
    check("bp_release_ready", {63'd0, req_ready}, 64'd1);
    drain();

    // Top-of-memory write: wraps to 0 or errors depending on build
    send(1'b1, AW'((1 << RW) - 3), 64'hA1A2A3A4A5A6A7A8, 8'hFF, 1'b1);
    send(1'b0, 'h0, '0, 8'h00, 1'b1);
    send(1'b0, AW'((1 << RW) - 8), '0, 8'h00, 1'b1);
    // Upper address bits set
    send(1'b0, (AW'(1) << 40) | AW'('h10), '0, 8'h00, 1'b1);
    send(1'b1, (AW'(1) << 40) | AW'('h30), 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b1);
    send(1'b0, 'h30, '0, 8'h00, 1'b1);

    // Mixed random traffic, including misaligned and partial strobes
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, (1 << RW) - 1)),
           {$urandom, $urandom}, 8'($urandom), 1'b1);
    end
    drain();

    // Reset while waiting: no response, ready again afterwards
    send(1'b0, 'h10, '0, 8'h00, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstwait_req_ready", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rstwait_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    send(1'b0, 'h10, '0, 8'h00, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
